// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide controller: computes mult/div results into a shadow pair,
// counts down the unit latency, then commits to the architectural HI/LO registers.
module e_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q, lo_q, sh_hi_q, sh_lo_q;
  logic          dz_q, busy_q;

  logic          is_start_s, is_signed_s, is_div_s;
  logic [63:0]   prod_s;
  logic [31:0]   a_mag_s, b_mag_s, q_mag_s, r_mag_s;
  logic [31:0]   res_hi_d, res_lo_d;
  logic          dz_d;
  logic [CW-1:0] cnt_load_d;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? neg32(v) : v;
  endfunction

  // Decode the issued op and compute its 64-bit result ahead of the issue edge
  always_comb begin
    is_start_s  = 1'b0;
    is_signed_s = 1'b0;
    is_div_s    = 1'b0;
    case (md_op)
      3'd1:    begin is_start_s = 1'b1; is_signed_s = 1'b1; end
      3'd2:    begin is_start_s = 1'b1; end
      3'd3:    begin is_start_s = 1'b1; is_signed_s = 1'b1; is_div_s = 1'b1; end
      3'd4:    begin is_start_s = 1'b1; is_div_s = 1'b1; end
      default: begin is_start_s = 1'b0; end
    endcase

    if (is_signed_s) begin
      prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    end else begin
      prod_s = {32'd0, a} * {32'd0, b};
    end

    // Divide on magnitudes so the most-negative / -1 case never overflows
    a_mag_s = mag32(a, is_signed_s);
    b_mag_s = mag32(b, is_signed_s);
    if (b_mag_s == 32'd0) begin
      q_mag_s = 32'd0;
      r_mag_s = 32'd0;
    end else begin
      q_mag_s = a_mag_s / b_mag_s;
      r_mag_s = a_mag_s % b_mag_s;
    end

    if (is_div_s) begin
      res_lo_d   = (is_signed_s && (a[31] ^ b[31])) ? neg32(q_mag_s) : q_mag_s;
      res_hi_d   = (is_signed_s && a[31]) ? neg32(r_mag_s) : r_mag_s;
      dz_d       = (b == 32'd0);
      cnt_load_d = CW'(DIV_CYCLES);
    end else begin
      res_lo_d   = prod_s[31:0];
      res_hi_d   = prod_s[63:32];
      dz_d       = 1'b0;
      cnt_load_d = CW'(MULT_CYCLES);
    end
  end

  // Controller FSM: issue, latency countdown and HI/LO commit
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      sh_hi_q <= 32'd0;
      sh_lo_q <= 32'd0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          case (md_op)
            3'd1, 3'd2, 3'd3, 3'd4: begin
              sh_hi_q <= res_hi_d;
              sh_lo_q <= res_lo_d;
              dz_q    <= dz_d;
              cnt_q   <= cnt_load_d;
              busy_q  <= 1'b1;
              state_q <= S_RUN;
            end
            3'd5:    hi_q <= a;
            3'd6:    lo_q <= a;
            default: state_q <= S_IDLE;
          endcase
        end
        S_RUN: begin
          // New ops arriving here are dropped; the hazard unit never sends them
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            if (!dz_q) begin
              hi_q <= sh_hi_q;
              lo_q <= sh_lo_q;
            end
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = busy_q;
  assign stall = busy_q | is_start_s;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Randomised self-checking bench for e_mdu_ctrl against a cycle-numbered reference model.
module tb_e_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, stall;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: committed values plus the edge number at which a pending result lands
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_dz;
  int          last_edge, done_at;

  e_mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic void ref_exec(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                                   output logic [31:0] rh, output logic [31:0] rl, output bit dz);
    int          sa, sb;
    longint      sp;
    longint unsigned up;
    sa = av; sb = bv; dz = 0; rh = 32'd0; rl = 32'd0;
    case (op)
      3'd1: begin sp = longint'(sa) * longint'(sb); rh = sp[63:32]; rl = sp[31:0]; end
      3'd2: begin up = longint'({32'd0, av}) * longint'({32'd0, bv}); rh = up[63:32]; rl = up[31:0]; end
      3'd3: begin
        if (sb == 0) dz = 1;
        else if (sa == 32'sh80000000 && sb == -1) begin rl = av; rh = 32'd0; end
        else begin rl = sa / sb; rh = sa % sb; end
      end
      3'd4: begin
        if (bv == 32'd0) dz = 1;
        else begin rl = av / bv; rh = av % bv; end
      end
      default: dz = 0;
    endcase
  endfunction

  // Drive one cycle's inputs, check stall before the edge, advance model, check state after
  task automatic step(input logic r, input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    int  this_edge;
    bit  busy_now;
    reset = r; md_op = op; a = av; b = bv;
    #1;
    this_edge = last_edge + 1;
    busy_now  = (last_edge < done_at);
    chk("stall", {31'd0, stall}, {31'd0, (busy_now || (op >= 3'd1 && op <= 3'd4))});
    if (r) begin
      m_hi = 32'd0; m_lo = 32'd0; done_at = -1;
    end else if (busy_now) begin
      if (this_edge == done_at && !p_dz) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (op >= 3'd1 && op <= 3'd4) begin
      ref_exec(op, av, bv, p_hi, p_lo, p_dz);
      done_at = this_edge + ((op <= 3'd2) ? MC : DC);
    end else if (op == 3'd5) begin
      m_hi = av;
    end else if (op == 3'd6) begin
      m_lo = av;
    end
    last_edge = this_edge;
    @(posedge clk);
    #1;
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("busy", {31'd0, busy}, {31'd0, (last_edge < done_at)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, $urandom, $urandom);
  endtask

  initial begin
    int          nb;
    logic [2:0]  op;
    logic [31:0] av, bv;
    reset = 1'b1; md_op = 3'd0; a = 32'd0; b = 32'd0;
    @(posedge clk);
    #1;
    m_hi = 32'd0; m_lo = 32'd0; last_edge = 0; done_at = -1;
    step(1'b1, 3'd0, 32'd0, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    step(1'b0, 3'd5, 32'h12345678, 32'd0);
    chk("mthi", hi, 32'h12345678);

    step(1'b0, 3'd1, 32'hFFFFFFFE, 32'd3);
    nb = 1;
    for (int i = 0; i < 8 && busy; i++) begin
      step(1'b0, 3'd0, 32'd0, 32'd0);
      if (busy) nb++;
    end
    chk("mult_busy_len", nb, MC);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    idle(1);

    step(1'b0, 3'd2, 32'hFFFFFFFE, 32'd3);
    idle(MC);
    chk("multu_hi", hi, 32'h00000002);
    chk("multu_lo", lo, 32'hFFFFFFFA);

    step(1'b0, 3'd3, 32'hFFFFFFF9, 32'd2);
    idle(DC);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    step(1'b0, 3'd3, 32'h80000000, 32'hFFFFFFFF);
    idle(DC);
    chk("divov_lo", lo, 32'h80000000);
    chk("divov_hi", hi, 32'd0);

    step(1'b0, 3'd4, 32'd7, 32'd0);
    idle(DC);
    chk("divz_lo", lo, 32'h80000000);
    chk("divz_hi", hi, 32'd0);

    step(1'b0, 3'd1, 32'hFFFFFFFE, 32'd3);
    step(1'b0, 3'd6, 32'h0000AAAA, 32'd0);
    idle(MC - 1);
    chk("mtlo_ign_lo", lo, 32'hFFFFFFFA);
    chk("mtlo_ign_busy", {31'd0, busy}, 32'd0);

    step(1'b0, 3'd3, 32'd100, 32'd7);
    idle(3);
    step(1'b1, 3'd0, 32'd0, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    idle(DC + 2);
    chk("rst_mid_lo", lo, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      op = 3'($urandom_range(0, 7));
      av = $urandom;
      bv = $urandom;
      case ($urandom_range(0, 9))
        0:       bv = 32'd0;
        1:       begin av = 32'h80000000; bv = 32'hFFFFFFFF; end
        2:       bv = 32'($urandom_range(1, 9));
        default: bv = bv;
      endcase
      step(($urandom_range(0, 59) == 0), op, av, bv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
